// File: rtl/booth8_pkg.sv
// Shared types and helpers for the radix-8 Booth multiplier: digit codes,
// digit count and the 4-bit window encoder.
package booth8_pkg;

   localparam int unsigned LAT = 4;

   typedef enum logic [3:0] {
      ZERO, P1, P2, P3, P4, N1, N2, N3, N4
   } digit_e;

   function automatic int unsigned num_digits(input int unsigned n);
      return (n + 3) / 3;
   endfunction

   // Window {b[3i+2], b[3i+1], b[3i], b[3i-1]} -> digit in [-4, +4]
   function automatic digit_e booth8_encode(input logic [3:0] win);
      digit_e d;
      case (win)
         4'b0001, 4'b0010: d = P1;
         4'b0011, 4'b0100: d = P2;
         4'b0101, 4'b0110: d = P3;
         4'b0111:          d = P4;
         4'b1000:          d = N4;
         4'b1001, 4'b1010: d = N3;
         4'b1011, 4'b1100: d = N2;
         4'b1101, 4'b1110: d = N1;
         default:          d = ZERO;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/booth8_pp_gen.sv
// One radix-8 Booth partial-product row: selects the multiple of A named by the
// window and returns it one's-complemented with a separate negate bit.
module booth8_pp_gen
   import booth8_pkg::*;
#(
   parameter int unsigned N = 16
) (
   input  logic [3:0]   win_i,
   input  logic [N:0]   a_i,
   input  logic [N+2:0] a3_i,
   output logic [N+2:0] row_c_o,
   output logic         neg_c_o
);

   digit_e       dig;
   logic [N+2:0] a_se;
   logic [N+2:0] mag;

   assign dig  = booth8_encode(win_i);
   assign a_se = (N+3)'($signed(a_i));

   always_comb begin
      mag     = '0;
      neg_c_o = 1'b0;
      case (dig)
         P1, N1: mag = a_se;
         P2, N2: mag = a_se << 1;
         P3, N3: mag = a3_i;
         P4, N4: mag = a_se << 2;
         default: mag = '0;
      endcase
      neg_c_o = (dig == N1) || (dig == N2) || (dig == N3) || (dig == N4);
      row_c_o = neg_c_o ? ~mag : mag;
   end

endmodule

// File: rtl/radix8_booth_mult_pipe.sv
// Four-stage pipelined radix-8 Booth multiplier (capture, recode, CSA reduce,
// final add) with per-transaction signedness and valid/ready back-pressure.
module radix8_booth_mult_pipe
   import booth8_pkg::*;
#(
   parameter int unsigned N = 16
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic           in_signed,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*N-1:0] prod
);

   localparam int unsigned NUM_DIGITS = num_digits(N);
   localparam int unsigned W          = 2*N + 2;
   localparam int unsigned BW         = 3*NUM_DIGITS;

   logic adv;

   logic         v0_q, s0_q;
   logic [N-1:0] a0_q, b0_q;

   logic [N:0]   a_ext, b_ext;
   logic [N+2:0] a_se, a3;
   logic [BW:0]  b_pad;

   logic [W-1:0]          pp_d [NUM_DIGITS];
   logic [W-1:0]          pp_q [NUM_DIGITS];
   logic [NUM_DIGITS-1:0] neg_c;
   logic [W-1:0]          negrow_d, negrow_q;
   logic                  v1_q;

   logic [W-1:0] sum_d, carry_d, sum_q, carry_q;
   logic         v2_q;

   logic [2*N-1:0] prod_d, prod_q;
   logic           out_valid_q;

   assign adv       = !out_valid_q || out_ready;
   assign in_ready  = adv;
   assign out_valid = out_valid_q;
   assign prod      = prod_q;

   // Operand extension, 3A and multiplier padding (LSB is the implicit 0)
   assign a_ext = {s0_q & a0_q[N-1], a0_q};
   assign b_ext = {s0_q & b0_q[N-1], b0_q};
   assign a_se  = (N+3)'($signed(a_ext));
   assign a3    = (a_se << 1) + a_se;
   assign b_pad = {BW'($signed(b_ext)), 1'b0};

   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_row
      logic [N+2:0] row;
      logic         neg;
      booth8_pp_gen #(.N(N)) u_pp (
         .win_i   (b_pad[3*i+3 -: 4]),
         .a_i     (a_ext),
         .a3_i    (a3),
         .row_c_o (row),
         .neg_c_o (neg)
      );
      assign pp_d[i]  = W'($signed(row)) << (3*i);
      assign neg_c[i] = neg;
   end

   // Negate bits land at column 3i of their own row
   for (genvar j = 0; j < W; j++) begin : g_negrow
      if ((j % 3 == 0) && (j / 3 < NUM_DIGITS)) begin : g_bit
         assign negrow_d[j] = neg_c[j/3];
      end else begin : g_zero
         assign negrow_d[j] = 1'b0;
      end
   end

   // Linear chain of 3:2 compressors over the rows plus the negate row
   for (genvar k = 0; k < NUM_DIGITS - 1; k++) begin : g_csa
      logic [W-1:0] x, y, z, s, c;
      if (k == 0) begin : g_first
         assign x = pp_q[0];
         assign y = pp_q[1];
      end else begin : g_next
         assign x = g_csa[k-1].s;
         assign y = g_csa[k-1].c;
      end
      if (k + 2 < NUM_DIGITS) begin : g_pp_in
         assign z = pp_q[k+2];
      end else begin : g_neg_in
         assign z = negrow_q;
      end
      assign s = x ^ y ^ z;
      assign c = ((x & y) | (x & z) | (y & z)) << 1;
   end

   assign sum_d   = g_csa[NUM_DIGITS-2].s;
   assign carry_d = g_csa[NUM_DIGITS-2].c;
   assign prod_d  = (2*N)'(sum_q + carry_q);

   // Whole pipe advances together; prod only loads on a valid result
   always_ff @(posedge clk) begin
      if (rst) begin
         v0_q        <= 1'b0;
         v1_q        <= 1'b0;
         v2_q        <= 1'b0;
         out_valid_q <= 1'b0;
         prod_q      <= '0;
      end else if (adv) begin
         v0_q        <= in_valid;
         a0_q        <= a;
         b0_q        <= b;
         s0_q        <= in_signed;
         v1_q        <= v0_q;
         pp_q        <= pp_d;
         negrow_q    <= negrow_d;
         v2_q        <= v1_q;
         sum_q       <= sum_d;
         carry_q     <= carry_d;
         out_valid_q <= v2_q;
         if (v2_q) begin
            prod_q <= prod_d;
         end
      end
   end

endmodule

// File: tb/tb_radix8_booth_mult_pipe.sv
// Directed-vector bench for radix8_booth_mult_pipe (N=16): table streams,
// latency/back-to-back, back-pressure, mid-flight reset and a random sweep.
module tb_radix8_booth_mult_pipe;
   import booth8_pkg::*;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic        in_signed;
   logic [15:0] a;
   logic [15:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] prod;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        sgn;
      logic [31:0] exp;
   } vec_t;

   vec_t        vq[$];
   logic [31:0] eq[$];
   vec_t        tbl [16];

   radix8_booth_mult_pipe #(.N(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_signed (in_signed),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .prod      (prod)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y,
                                           input logic s);
      logic signed [31:0] xs, ys;
      logic [31:0]        xu, yu;
      xs = 32'($signed(x));
      ys = 32'($signed(y));
      xu = {16'h0, x};
      yu = {16'h0, y};
      return s ? 32'(xs * ys) : 32'(xu * yu);
   endfunction

   // Drives vq in order, checks results against the expected queue in order;
   // out_ready is low for cycles stall_lo..stall_hi (cycle 1 = first iteration)
   task automatic run_stream(input int stall_lo, input int stall_hi, input string tag,
                             output int first_in, output int first_out, output int last_out);
      int cyc;
      int total;
      int got;
      logic [31:0] e;
      cyc = 0; got = 0; total = vq.size();
      first_in = -1; first_out = -1; last_out = -1;
      while (got < total && cyc < 2000) begin
         cyc++;
         out_ready = !(cyc >= stall_lo && cyc <= stall_hi);
         if (vq.size() > 0) begin
            in_valid  = 1'b1;
            a         = vq[0].a;
            b         = vq[0].b;
            in_signed = vq[0].sgn;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (out_valid) begin
            if (eq.size() == 0) begin
               check({tag, "_spurious"}, prod, 32'hxxxx_xxxx);
            end else if (out_ready) begin
               e = eq.pop_front();
               check({tag, "_prod"}, prod, e);
               got++;
               if (first_out < 0) first_out = cyc;
               last_out = cyc;
            end else begin
               check({tag, "_stall_in_ready"}, {31'h0, in_ready}, 32'h0);
               check({tag, "_stall_prod"}, prod, eq[0]);
            end
         end
         if (in_valid && in_ready) begin
            if (first_in < 0) first_in = cyc;
            eq.push_back(vq[0].exp);
            void'(vq.pop_front());
         end
         @(posedge clk);
         #1;
      end
      if (got < total) check({tag, "_timeout_results"}, 32'(got), 32'(total));
      in_valid  = 1'b0;
      out_ready = 1'b1;
      vq.delete();
      eq.delete();
   endtask

   initial begin
      int fi, fo, lo;
      logic [15:0] ra, rb;
      logic        rs;

      rst = 1'b1; in_valid = 1'b0; in_signed = 1'b0; a = '0; b = '0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("reset_out_valid", {31'h0, out_valid}, 32'h0);
      check("reset_prod", prod, 32'h0);
      check("reset_in_ready", {31'h0, in_ready}, 32'h1);

      // Most-negative squared, and pipeline latency
      vq.push_back('{16'h8000, 16'h8000, 1'b1, 32'h4000_0000});
      run_stream(0, -1, "latency", fi, fo, lo);
      check("latency_cycles", 32'(fo - fi), 32'(LAT));

      // Same operands, unsigned then signed, back to back
      vq.push_back('{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001});
      vq.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 32'h0000_0001});
      run_stream(0, -1, "mixed", fi, fo, lo);
      check("mixed_consecutive", 32'(lo - fo), 32'h1);

      tbl = '{
         '{16'h1234, 16'h0004, 1'b1, 32'h0000_48D0},
         '{16'h1234, 16'hFFFC, 1'b1, 32'hFFFF_B730},
         '{16'h7FFF, 16'h7FFF, 1'b1, 32'h3FFF_0001},
         '{16'h7FFF, 16'h8000, 1'b1, 32'hC000_8000},
         '{16'h8000, 16'h8000, 1'b0, 32'h4000_0000},
         '{16'hFFFF, 16'h0001, 1'b1, 32'hFFFF_FFFF},
         '{16'hFFFF, 16'h0001, 1'b0, 32'h0000_FFFF},
         '{16'h0000, 16'h8000, 1'b1, 32'h0000_0000},
         '{16'hFFFF, 16'h0000, 1'b0, 32'h0000_0000},
         '{16'h00FF, 16'h0101, 1'b0, 32'h0000_FFFF},
         '{16'h1234, 16'hFFFF, 1'b1, 32'hFFFF_EDCC},
         '{16'hC000, 16'h0007, 1'b1, 32'hFFFE_4000},
         '{16'hABCD, 16'h0002, 1'b0, 32'h0001_579A},
         '{16'h8000, 16'hFFFF, 1'b0, 32'h7FFF_8000},
         '{16'h8000, 16'hFFFF, 1'b1, 32'h0000_8000},
         '{16'h0003, 16'h0005, 1'b1, 32'h0000_000F}
      };
      foreach (tbl[i]) vq.push_back(tbl[i]);
      run_stream(0, -1, "table", fi, fo, lo);
      check("table_throughput", 32'(lo - fo), 32'(15));

      // Back-pressure: a=k, b=k+1 with out_ready low for cycles 5..9
      for (int k = 1; k <= 8; k++) vq.push_back('{16'(k), 16'(k + 1), 1'b1, 32'(k * (k + 1))});
      run_stream(5, 9, "bp", fi, fo, lo);
      check("bp_first_out", 32'(fo), 32'(10));
      check("bp_no_gap", 32'(lo - fo), 32'(7));

      // Reset on the third of three transfers: nothing may emerge
      for (int c = 0; c < 3; c++) begin
         in_valid  = 1'b1;
         in_signed = 1'b1;
         a         = 16'(c + 3);
         b         = 16'(c + 7);
         rst       = (c == 2);
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
      in_valid = 1'b0;
      for (int c = 0; c < 6; c++) begin
         check("rst_out_valid", {31'h0, out_valid}, 32'h0);
         check("rst_prod", prod, 32'h0);
         @(posedge clk);
         #1;
      end

      // Random operands in both modes against a reference multiply
      for (int i = 0; i < 200; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         rs = 1'($urandom_range(0, 1));
         vq.push_back('{ra, rb, rs, ref_mul(ra, rb, rs)});
      end
      run_stream(40, 47, "rand", fi, fo, lo);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
